// File: rtl/npc_pkg.sv
// Shared NPC execute-stage types.
// Shift opcode encoding and small opcode classifiers.
package npc_pkg;

  localparam int SHIFT_OP_W = 3;

  typedef enum logic [SHIFT_OP_W-1:0] {
    SH_SLL = 3'b000,
    SH_SRL = 3'b001,
    SH_SRA = 3'b010,
    SH_ROL = 3'b011,
    SH_ROR = 3'b100
  } shift_op_e;

  // Rotates wrap bits around instead of filling.
  function automatic logic op_rot(
    input logic [SHIFT_OP_W-1:0] op
  );
    return (op == SH_ROL) || (op == SH_ROR);
  endfunction

  // Right-going ops run bit-reversed through the left network.
  function automatic logic op_rev(
    input logic [SHIFT_OP_W-1:0] op
  );
    return (op == SH_SRL) || (op == SH_SRA) ||
           (op == SH_ROR);
  endfunction

  function automatic logic op_rsv(
    input logic [SHIFT_OP_W-1:0] op
  );
    return op > SH_ROR;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline slice of the shift network.
// Applies mux levels LO..HI, then registers the payload.
module shift_stage
  import npc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LO    = 0,
  parameter int HI    = 0,
  localparam int L    = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [L-1:0]          in_shamt,
  input  logic [SHIFT_OP_W-1:0] in_op,
  input  logic                  in_word,
  input  logic                  in_fill,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [L-1:0]          out_shamt,
  output logic [SHIFT_OP_W-1:0] out_op,
  output logic                  out_word,
  output logic                  out_fill
);

  logic             valid_q;
  logic             rot;
  logic [WIDTH-1:0] net;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign rot       = op_rot(in_op) && !in_word;

  // Left shift by 2^k per set shamt bit; wrap or constant fill.
  always_comb begin
    net = in_data;
    for (int k = LO; k <= HI; k++) begin
      if (in_shamt[k]) begin
        if (rot)
          net = (net << (1 << k)) |
                (net >> (WIDTH - (1 << k)));
        else
          net = (net << (1 << k)) |
                (in_fill ? ~({WIDTH{1'b1}} << (1 << k))
                         : {WIDTH{1'b0}});
      end
    end
  end

  // Occupancy bit: load when slot frees, cleared by flush/reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      valid_q <= 1'b0;
    else if (flush)
      valid_q <= 1'b0;
    else if (in_ready)
      valid_q <= in_valid;
  end

  // Payload register; contents are masked by valid_q.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      out_data  <= net;
      out_shamt <= in_shamt;
      out_op    <= in_op;
      out_word  <= in_word;
      out_fill  <= in_fill;
    end
  end

endmodule

// File: rtl/shift_unit.sv
// Pipelined barrel shifter for the NPC execute stage.
// Right ops and rotates reuse one left network via bit reversal.
module shift_unit
  import npc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SHIFT_OP_W-1:0]    in_op,
  input  logic                     in_word,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [$clog2(WIDTH)-1:0] in_shamt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data
);

  localparam int L = $clog2(WIDTH);

  logic                  wmode;
  logic [WIDTH-1:0]      rv;
  logic [31:0]           r32;
  logic [31:0]           s32;
  logic [WIDTH-1:0]      x;
  logic [L-1:0]          sh0;
  logic                  fill0;

  logic [WIDTH-1:0]      y;
  logic [SHIFT_OP_W-1:0] yop;
  logic                  yw;
  logic [WIDTH-1:0]      yrev;
  logic [31:0]           top32;
  logic [31:0]           t32;
  logic [31:0]           res32;
  logic [WIDTH-1:0]      wext;

  assign wmode = (WIDTH == 64) && in_word;

  // Front end: pre-reverse, pick fill bit, lay out word operands.
  // Word ops sit in the top half; the low half feeds wrap or fill.
  always_comb begin
    for (int i = 0; i < WIDTH; i++)
      rv[i] = in_data[WIDTH-1-i];
    for (int i = 0; i < 32; i++)
      r32[i] = in_data[31-i];
    s32   = op_rev(in_op) ? r32 : in_data[31:0];
    fill0 = (in_op == SH_SRA) &&
            (wmode ? in_data[31] : in_data[WIDTH-1]);
    sh0   = in_shamt;
    if (wmode)
      sh0[L-1] = 1'b0;
    x = '0;
    if (op_rsv(in_op)) begin
      fill0 = 1'b0;
    end else if (wmode) begin
      x[WIDTH-1 -: 32] = s32;
      x[31:0] = op_rot(in_op) ? s32 : {32{fill0}};
    end else begin
      x = op_rev(in_op) ? rv : in_data;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = (s * L) / STAGES;
    localparam int HI = ((s + 1) * L) / STAGES - 1;

    logic                  iv;
    logic                  ir;
    logic [WIDTH-1:0]      id;
    logic [L-1:0]          ish;
    logic [SHIFT_OP_W-1:0] iop;
    logic                  iw;
    logic                  ifl;
    logic                  ov;
    logic                  orr;
    logic [WIDTH-1:0]      od;
    logic [L-1:0]          osh;
    logic [SHIFT_OP_W-1:0] oop;
    logic                  ow;
    logic                  ofl;

    if (s == 0) begin : g_head
      assign iv  = in_valid;
      assign id  = x;
      assign ish = sh0;
      assign iop = in_op;
      assign iw  = wmode;
      assign ifl = fill0;
    end else begin : g_link
      assign iv  = g_st[s-1].ov;
      assign id  = g_st[s-1].od;
      assign ish = g_st[s-1].osh;
      assign iop = g_st[s-1].oop;
      assign iw  = g_st[s-1].ow;
      assign ifl = g_st[s-1].ofl;
    end

    if (s == STAGES - 1) begin : g_tail
      assign orr = out_ready;
    end else begin : g_back
      assign orr = g_st[s+1].ir;
    end

    shift_stage #(
      .WIDTH (WIDTH),
      .LO    (LO),
      .HI    (HI)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_data   (id),
      .in_shamt  (ish),
      .in_op     (iop),
      .in_word   (iw),
      .in_fill   (ifl),
      .out_valid (ov),
      .out_ready (orr),
      .out_data  (od),
      .out_shamt (osh),
      .out_op    (oop),
      .out_word  (ow),
      .out_fill  (ofl)
    );
  end

  assign in_ready  = g_st[0].ir;
  assign out_valid = g_st[STAGES-1].ov;
  assign y         = g_st[STAGES-1].od;
  assign yop       = g_st[STAGES-1].oop;
  assign yw        = g_st[STAGES-1].ow;

  // Back end: undo reversal, sign-extend word results.
  always_comb begin
    for (int i = 0; i < WIDTH; i++)
      yrev[i] = y[WIDTH-1-i];
    top32 = y[WIDTH-1 -: 32];
    for (int i = 0; i < 32; i++)
      t32[i] = top32[31-i];
    res32 = op_rev(yop) ? t32 : top32;
    for (int i = 0; i < WIDTH; i++)
      wext[i] = (i < 32) ? res32[i[4:0]] : res32[31];
    out_data = yw ? wext : (op_rev(yop) ? yrev : y);
  end

endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: three configs in lockstep,
// directed cases then random traffic against a model.
module tb_shift_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int WD [3] = '{32, 64, 64};
  int ST [3] = '{2, 3, 6};

  logic        fl   [3];
  logic        iv   [3];
  logic        orr  [3];
  logic        wd   [3];
  logic [2:0]  op   [3];
  logic [63:0] din  [3];
  logic [5:0]  sh   [3];
  logic [63:0] nexp [3];

  logic        a_ir, a_ov;
  logic [31:0] a_od;
  logic        b_ir, b_ov;
  logic [63:0] b_od;
  logic        c_ir, c_ov;
  logic [63:0] c_od;

  shift_unit #(.WIDTH(32), .STAGES(2)) u_a (
    .clk(clk), .rst(rst), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(a_ir),
    .in_op(op[0]), .in_word(wd[0]),
    .in_data(din[0][31:0]), .in_shamt(sh[0][4:0]),
    .out_valid(a_ov), .out_ready(orr[0]),
    .out_data(a_od)
  );

  shift_unit #(.WIDTH(64), .STAGES(3)) u_b (
    .clk(clk), .rst(rst), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(b_ir),
    .in_op(op[1]), .in_word(wd[1]),
    .in_data(din[1]), .in_shamt(sh[1]),
    .out_valid(b_ov), .out_ready(orr[1]),
    .out_data(b_od)
  );

  shift_unit #(.WIDTH(64), .STAGES(6)) u_c (
    .clk(clk), .rst(rst), .flush(fl[2]),
    .in_valid(iv[2]), .in_ready(c_ir),
    .in_op(op[2]), .in_word(wd[2]),
    .in_data(din[2]), .in_shamt(sh[2]),
    .out_valid(c_ov), .out_ready(orr[2]),
    .out_data(c_od)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [63:0] qd [3][$];
  int          qc [3][$];
  int          pushes [3];
  int          lstall [3];
  logic        pstall [3];
  logic [63:0] pdata  [3];
  logic        fullseen [3];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp_v);
    end
  endtask

  // Plain-arithmetic reference of the shift rules.
  function automatic logic [63:0] model(
    input int w, input logic [2:0] o, input logic word,
    input logic [63:0] d, input int s);
    int n;
    logic [63:0] m, r;
    n = (w == 64 && word) ? 32 : w;
    m = (n == 64) ? '1 : 64'hFFFF_FFFF;
    s = s % n;
    d = d & m;
    case (o)
      3'd0: r = (d << s) & m;
      3'd1: r = d >> s;
      3'd2: r = (d >> s) |
                (d[n-1] ? (m & ~(m >> s)) : 64'h0);
      3'd3: r = (s == 0) ? d :
                ((d << s) | (d >> (n - s))) & m;
      3'd4: r = (s == 0) ? d :
                ((d >> s) | (d << (n - s))) & m;
      default: r = 64'h0;
    endcase
    if (n == 32 && w == 64)
      r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  task automatic eval(input int k);
    logic ir, ov;
    logic [63:0] od, e;
    int c;
    case (k)
      0: begin ir = a_ir; ov = a_ov; od = {32'h0, a_od}; end
      1: begin ir = b_ir; ov = b_ov; od = b_od; end
      default: begin ir = c_ir; ov = c_ov; od = c_od; end
    endcase
    if (pstall[k]) begin
      chk($sformatf("d%0d_stall_valid", k), 64'(ov), 64'd1);
      chk($sformatf("d%0d_stall_data", k), od, pdata[k]);
    end
    if (!fl[k])
      chk($sformatf("d%0d_in_ready", k), 64'(ir),
          64'((qd[k].size() < ST[k]) || orr[k]));
    if (qd[k].size() >= ST[k] && !orr[k] && !ir)
      fullseen[k] = 1'b1;
    if (ov && orr[k]) begin
      if (qd[k].size() == 0) begin
        chk($sformatf("d%0d_spurious", k), 64'(ov), 64'd0);
      end else begin
        e = qd[k].pop_front();
        c = qc[k].pop_front();
        chk($sformatf("d%0d_data", k), od, e);
        if (lstall[k] < c)
          chk($sformatf("d%0d_latency", k),
              64'(cyc - c), 64'(ST[k]));
      end
    end
    if (fl[k]) begin
      qd[k].delete();
      qc[k].delete();
    end else if (iv[k] && ir) begin
      qd[k].push_back(nexp[k]);
      qc[k].push_back(cyc);
      pushes[k]++;
    end
    if (ov && !orr[k])
      lstall[k] = cyc;
    pstall[k] = ov && !orr[k] && !fl[k];
    pdata[k]  = od;
  endtask

  task automatic step();
    #1;
    for (int k = 0; k < 3; k++)
      eval(k);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input int k, input logic [2:0] o,
                      input logic w, input logic [63:0] dd,
                      input logic [5:0] s,
                      input logic [63:0] e);
    iv[k]   = 1'b1;
    op[k]   = o;
    wd[k]   = w;
    din[k]  = dd;
    sh[k]   = s;
    orr[k]  = 1'b1;
    nexp[k] = e;
    step();
    iv[k]   = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 3; k++) begin
      iv[k]  = 1'b0;
      orr[k] = 1'b1;
      fl[k]  = 1'b0;
    end
    repeat (n) step();
    for (int k = 0; k < 3; k++)
      chk($sformatf("d%0d_drain", k),
          64'(qd[k].size()), 64'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fl[k] = 0; iv[k] = 0; orr[k] = 0; wd[k] = 0;
      op[k] = 0; din[k] = 0; sh[k] = 0; nexp[k] = 0;
      pushes[k] = 0; lstall[k] = -1; pstall[k] = 0;
      pdata[k] = 0; fullseen[k] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst_a_ov", 64'(a_ov), 64'd0);
    chk("rst_a_ir", 64'(a_ir), 64'd1);
    chk("rst_b_ov", 64'(b_ov), 64'd0);
    chk("rst_c_ir", 64'(c_ir), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    send(0, 3'd2, 0, 64'h8000_0000, 6'd4, 64'hF800_0000);
    send(0, 3'd1, 0, 64'h8000_0000, 6'd4, 64'h0800_0000);
    send(0, 3'd0, 0, 64'h1, 6'd31, 64'h8000_0000);
    send(0, 3'd4, 0, 64'hF1, 6'd4, 64'h1000_000F);
    send(0, 3'd3, 0, 64'h8000_0001, 6'd1, 64'h3);
    for (int o = 0; o < 5; o++)
      send(0, 3'(o), 0, 64'hC3A5_0F96, 6'd0, 64'hC3A5_0F96);
    send(0, 3'd7, 0, 64'hDEAD_BEEF, 6'd5, 64'h0);
    send(0, 3'd7, 0, 64'hDEAD_BEEF, 6'd0, 64'h0);
    send(0, 3'd5, 0, 64'h8000_0001, 6'd3, 64'h0);
    drain(6);

    for (int k = 1; k < 3; k++) begin
      send(k, 3'd2, 1, 64'h8000_0000, 6'd1,
           64'hFFFF_FFFF_C000_0000);
      send(k, 3'd0, 1, 64'h1, 6'd31,
           64'hFFFF_FFFF_8000_0000);
      send(k, 3'd1, 1, '1, 6'd4, 64'h0FFF_FFFF);
      send(k, 3'd0, 1, 64'h1, 6'd33, 64'h2);
      send(k, 3'd1, 1, 64'hDEAD_BEEF_F000_0000, 6'd33,
           64'h7800_0000);
      send(k, 3'd2, 0, 64'h8000_0000_0000_0000, 6'd63, '1);
      send(k, 3'd1, 0, '1, 6'd4, 64'h0FFF_FFFF_FFFF_FFFF);
      send(k, 3'd2, 0, 64'h8000_0000, 6'd1, 64'h4000_0000);
      send(k, 3'd4, 1, 64'hF1, 6'd4, 64'h1000_000F);
      send(k, 3'd3, 1, 64'h8000_0001, 6'd1, 64'h3);
      send(k, 3'd3, 0, 64'h8000_0000_0000_0001, 6'd1,
           64'h3);
    end
    drain(10);

    base = pushes[0];
    fullseen[0] = 1'b0;
    op[0] = 3'd3;
    wd[0] = 1'b0;
    for (int t = 0; t < 40; t++) begin
      int idx;
      idx = pushes[0] - base;
      iv[0]   = idx < 8;
      din[0]  = 64'hA5A5_0000 | 64'(idx);
      sh[0]   = 6'(idx * 3);
      nexp[0] = model(32, 3'd3, 0, din[0], (idx * 3) & 31);
      orr[0]  = !(t >= 4 && t < 9);
      step();
    end
    chk("bp_in_ready_fell", 64'(fullseen[0]), 64'd1);
    chk("bp_accepted", 64'(pushes[0] - base), 64'd8);
    drain(6);

    orr[0] = 1'b0;
    iv[0]  = 1'b1;
    op[0]  = 3'd0;
    din[0] = 64'h1;
    sh[0]  = 6'd2;
    nexp[0] = 64'h4;
    step();
    step();
    iv[0] = 1'b0;
    #2;
    chk("prerst_ov", 64'(a_ov), 64'd1);
    rst = 1'b1;
    #1;
    chk("midrst_ov", 64'(a_ov), 64'd0);
    chk("midrst_ir", 64'(a_ir), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      qd[k].delete();
      qc[k].delete();
      pstall[k] = 1'b0;
    end
    drain(8);

    orr[0] = 1'b0;
    iv[0]  = 1'b1;
    op[0]  = 3'd1;
    din[0] = 64'hF0;
    sh[0]  = 6'd4;
    nexp[0] = 64'hF;
    step();
    step();
    fl[0] = 1'b1;
    step();
    fl[0] = 1'b0;
    iv[0] = 1'b0;
    drain(6);
    send(0, 3'd2, 0, 64'h8000_00F0, 6'd4, 64'hF800_000F);
    drain(4);

    for (int t = 0; t < 4000; t++) begin
      for (int k = 0; k < 3; k++) begin
        iv[k]  = $urandom_range(0, 3) != 0;
        if ($urandom_range(0, 7) == 0)
          op[k] = 3'($urandom_range(5, 7));
        else
          op[k] = 3'($urandom_range(0, 4));
        wd[k]  = 1'($urandom_range(0, 1));
        din[k] = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0)
          din[k] = din[k] | 64'h8000_0000_8000_0000;
        sh[k]  = 6'($urandom_range(0, 63));
        orr[k] = $urandom_range(0, 2) != 0;
        nexp[k] = model(WD[k], op[k], wd[k], din[k],
                        int'(sh[k]) & (WD[k] - 1));
      end
      step();
    end
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
